// File: rtl/ctrl_decode.sv
// MIPS-subset instruction decoder: combinational one-hot instruction flags and datapath
// controls from Op/Func, plus a registered sticky record of any illegal encoding.
module ctrl_decode (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Func,
  output logic       R,
  output logic       addu,
  output logic       subu,
  output logic       jr,
  output logic       ori,
  output logic       lw,
  output logic       sw,
  output logic       beq,
  output logic       lui,
  output logic       j,
  output logic       jal,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic       ALUSrc,
  output logic       ExtOp,
  output logic [1:0] ALUOp,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       Branch,
  output logic       Jump,
  output logic       JumpReg,
  output logic       illegal,
  output logic       illegal_seen
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_JAL   = 6'b000011,
    OP_BEQ   = 6'b000100,
    OP_ORI   = 6'b001101,
    OP_LUI   = 6'b001111,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_e;

  typedef enum logic [5:0] {
    FN_NOP  = 6'b000000,
    FN_JR   = 6'b001000,
    FN_ADDU = 6'b100001,
    FN_SUBU = 6'b100011
  } func_e;

  logic seen_q = 1'b0;

  // Instruction flags; every unmatched encoding falls to the default arm and flags illegal.
  always_comb begin
    R       = 1'b0;
    addu    = 1'b0;
    subu    = 1'b0;
    jr      = 1'b0;
    ori     = 1'b0;
    lw      = 1'b0;
    sw      = 1'b0;
    beq     = 1'b0;
    lui     = 1'b0;
    j       = 1'b0;
    jal     = 1'b0;
    illegal = 1'b0;
    case (Op)
      OP_RTYPE: begin
        R = 1'b1;
        case (Func)
          FN_ADDU: addu    = 1'b1;
          FN_SUBU: subu    = 1'b1;
          FN_JR:   jr      = 1'b1;
          FN_NOP:  ;
          default: illegal = 1'b1;
        endcase
      end
      OP_ORI:  ori     = 1'b1;
      OP_LW:   lw      = 1'b1;
      OP_SW:   sw      = 1'b1;
      OP_BEQ:  beq     = 1'b1;
      OP_LUI:  lui     = 1'b1;
      OP_J:    j       = 1'b1;
      OP_JAL:  jal     = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

  // Illegal R-type still writes (R=1) but is steered to rt with ADD, matching the no-op rule.
  always_comb begin
    RegWrite = R | ori | lw | lui | jal;
    RegDst   = 2'd0;
    if (jal)
      RegDst = 2'd2;
    else if (R && !illegal)
      RegDst = 2'd1;
    ALUSrc   = ori | lw | sw | lui;
    ExtOp    = lw | sw | beq;
    ALUOp    = 2'd0;
    if (lui)
      ALUOp = 2'd3;
    else if (ori)
      ALUOp = 2'd2;
    else if (subu || beq)
      ALUOp = 2'd1;
    MemWrite = sw;
    MemtoReg = lw;
    Branch   = beq;
    Jump     = j | jal;
    JumpReg  = jr;
  end

  always_ff @(posedge clk) begin
    if (reset)
      seen_q <= 1'b0;
    else if (illegal)
      seen_q <= 1'b1;
  end

  assign illegal_seen = seen_q;

endmodule

// File: tb/tb_ctrl_decode.sv
// Bench for ctrl_decode: directed decodes, exhaustive Op/Func sweep, and randomized
// traffic against a per-instruction reference table, including the sticky illegal flag.
module tb_ctrl_decode;

  typedef struct packed {
    logic       R, addu, subu, jr, ori, lw, sw, beq, lui, j, jal;
    logic       RegWrite;
    logic [1:0] RegDst;
    logic       ALUSrc, ExtOp;
    logic [1:0] ALUOp;
    logic       MemWrite, MemtoReg, Branch, Jump, JumpReg, illegal;
  } ctrl_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op, Func;
  logic       R, addu, subu, jr, ori, lw, sw, beq, lui, j, jal;
  logic       RegWrite, ALUSrc, ExtOp, MemWrite, MemtoReg, Branch, Jump, JumpReg;
  logic       illegal, illegal_seen;
  logic [1:0] RegDst, ALUOp;
  ctrl_t      dut_c;
  ctrl_t      exp_c;
  logic       exp_seen;
  int         errors = 0;
  int         checks = 0;

  ctrl_decode dut (
    .clk(clk), .reset(reset), .Op(Op), .Func(Func),
    .R(R), .addu(addu), .subu(subu), .jr(jr), .ori(ori), .lw(lw), .sw(sw),
    .beq(beq), .lui(lui), .j(j), .jal(jal), .RegWrite(RegWrite), .RegDst(RegDst),
    .ALUSrc(ALUSrc), .ExtOp(ExtOp), .ALUOp(ALUOp), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .Branch(Branch), .Jump(Jump), .JumpReg(JumpReg),
    .illegal(illegal), .illegal_seen(illegal_seen)
  );

  always #5 clk = ~clk;

  assign dut_c = {R, addu, subu, jr, ori, lw, sw, beq, lui, j, jal, RegWrite, RegDst,
                  ALUSrc, ExtOp, ALUOp, MemWrite, MemtoReg, Branch, Jump, JumpReg, illegal};

  // Reference: each supported instruction lists its full control row directly.
  function automatic ctrl_t model(input logic [5:0] op, input logic [5:0] fn);
    ctrl_t m;
    m = '0;
    case (op)
      6'b000000: begin
        m.R = 1'b1;
        m.RegWrite = 1'b1;
        case (fn)
          6'b100001: begin m.addu = 1'b1; m.RegDst = 2'd1; end
          6'b100011: begin m.subu = 1'b1; m.RegDst = 2'd1; m.ALUOp = 2'd1; end
          6'b001000: begin m.jr = 1'b1; m.RegDst = 2'd1; m.JumpReg = 1'b1; end
          6'b000000: m.RegDst = 2'd1;
          default:   m.illegal = 1'b1;
        endcase
      end
      6'b001101: begin m.ori = 1'b1; m.RegWrite = 1'b1; m.ALUSrc = 1'b1; m.ALUOp = 2'd2; end
      6'b100011: begin m.lw = 1'b1; m.RegWrite = 1'b1; m.ALUSrc = 1'b1; m.ExtOp = 1'b1;
                       m.MemtoReg = 1'b1; end
      6'b101011: begin m.sw = 1'b1; m.ALUSrc = 1'b1; m.ExtOp = 1'b1; m.MemWrite = 1'b1; end
      6'b000100: begin m.beq = 1'b1; m.ExtOp = 1'b1; m.ALUOp = 2'd1; m.Branch = 1'b1; end
      6'b001111: begin m.lui = 1'b1; m.RegWrite = 1'b1; m.ALUSrc = 1'b1; m.ALUOp = 2'd3; end
      6'b000010: begin m.j = 1'b1; m.Jump = 1'b1; end
      6'b000011: begin m.jal = 1'b1; m.Jump = 1'b1; m.RegWrite = 1'b1; m.RegDst = 2'd2; end
      default:   m.illegal = 1'b1;
    endcase
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h (Op=%b Func=%b)", tag, obs, exp, Op, Func);
    end
  endtask

  // Apply one input set mid-cycle, check combinational outputs, clock, check the sticky flag.
  task automatic step(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                      input string tag);
    @(negedge clk);
    reset = rst;
    Op    = op;
    Func  = fn;
    #1;
    exp_c = model(op, fn);
    check({tag, "_ctrl"}, 32'(dut_c), 32'(exp_c));
    @(posedge clk);
    if (rst) exp_seen = 1'b0;
    else if (exp_c.illegal) exp_seen = 1'b1;
    #1;
    check({tag, "_seen"}, 32'(illegal_seen), 32'(exp_seen));
  endtask

  initial begin
    logic [5:0] legal_ops [8];
    logic [5:0] legal_fns [4];
    logic [5:0] rop, rfn;
    logic       rrst;
    int         flags;

    legal_ops = '{6'b000000, 6'b001101, 6'b100011, 6'b101011,
                  6'b000100, 6'b001111, 6'b000010, 6'b000011};
    legal_fns = '{6'b000000, 6'b100001, 6'b100011, 6'b001000};
    exp_seen = 1'b0;
    reset = 1'b1;
    Op = '0;
    Func = '0;

    // Power-up value before any edge, then reset state.
    #1;
    check("powerup_seen", 32'(illegal_seen), 32'(0));
    step(1'b1, 6'b000000, 6'b000000, "reset");

    // Directed decodes with spelled-out expectations.
    step(1'b0, 6'b000000, 6'b100001, "addu");
    check("addu_R", 32'(R), 1); check("addu_flag", 32'(addu), 1);
    check("addu_RegDst", 32'(RegDst), 1); check("addu_ALUOp", 32'(ALUOp), 0);
    check("addu_ALUSrc", 32'(ALUSrc), 0); check("addu_illegal", 32'(illegal), 0);
    step(1'b0, 6'b100011, 6'b010101, "lw");
    check("lw_flag", 32'(lw), 1); check("lw_RegDst", 32'(RegDst), 0);
    check("lw_ALUSrc", 32'(ALUSrc), 1); check("lw_ExtOp", 32'(ExtOp), 1);
    check("lw_MemtoReg", 32'(MemtoReg), 1); check("lw_RegWrite", 32'(RegWrite), 1);
    step(1'b0, 6'b101011, 6'b000000, "sw");
    check("sw_MemWrite", 32'(MemWrite), 1); check("sw_RegWrite", 32'(RegWrite), 0);
    step(1'b0, 6'b000100, 6'b111111, "beq");
    check("beq_Branch", 32'(Branch), 1); check("beq_ALUOp", 32'(ALUOp), 1);
    check("beq_ExtOp", 32'(ExtOp), 1); check("beq_RegWrite", 32'(RegWrite), 0);
    step(1'b0, 6'b000011, 6'b000000, "jal");
    check("jal_Jump", 32'(Jump), 1); check("jal_RegDst", 32'(RegDst), 2);
    check("jal_RegWrite", 32'(RegWrite), 1);
    step(1'b0, 6'b000000, 6'b001000, "jr");
    check("jr_JumpReg", 32'(JumpReg), 1); check("jr_RegWrite", 32'(RegWrite), 1);
    step(1'b0, 6'b000000, 6'b000000, "nop");
    check("nop_R", 32'(R), 1); check("nop_illegal", 32'(illegal), 0);
    check("nop_seen", 32'(illegal_seen), 0);

    // Illegal opcode: a no-op, sets sticky flag which then holds across legal traffic.
    step(1'b0, 6'b111111, 6'b000000, "badop");
    check("badop_en", 32'({RegWrite, MemWrite, Jump, Branch, JumpReg}), 0);
    check("badop_seen", 32'(illegal_seen), 1);
    step(1'b0, 6'b001101, 6'b000000, "hold");
    check("hold_seen", 32'(illegal_seen), 1);
    // Reset wins over a simultaneous illegal.
    step(1'b1, 6'b111111, 6'b000000, "rst_vs_illegal");
    check("rst_vs_illegal_seen", 32'(illegal_seen), 0);
    // Illegal R-type keeps R and RegWrite.
    step(1'b0, 6'b000000, 6'b100000, "badfunc");
    check("badfunc_R_RW", 32'({R, RegWrite, illegal}), 32'b111);

    // Exhaustive sweep with structural properties checked on the DUT outputs.
    step(1'b1, 6'b000000, 6'b000000, "sweep_reset");
    for (int unsigned k = 0; k < 4096; k++) begin
      step(1'b0, 6'(k >> 6), 6'(k), "sweep");
      flags = $countones({addu, subu, jr, ori, lw, sw, beq, lui, j, jal});
      check("sweep_onehot", 32'(flags <= 1), 1);
      check("sweep_regwrite", 32'(RegWrite), 32'(R | ori | lw | lui | jal));
    end

    // Randomized traffic biased toward legal encodings, with occasional resets.
    for (int unsigned n = 0; n < 400; n++) begin
      rop  = ($urandom_range(0, 3) != 0) ? legal_ops[$urandom_range(0, 7)] : 6'($urandom);
      rfn  = ($urandom_range(0, 1) != 0) ? legal_fns[$urandom_range(0, 3)] : 6'($urandom);
      rrst = ($urandom_range(0, 7) == 0);
      step(rrst, rop, rfn, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
